// File: rtl/avmm_pkg.sv
// Shared types and helpers for the Avalon-MM master bridge.
package avmm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CMD    = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_RESP   = 2'd3
  } avmm_state_t;

  // Number of byte lanes in a data word.
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop single-bit synchroniser, asynchronously cleared to 0.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/avmm_master_bridge.sv
// Single-word Avalon-MM master fed by a toggle request/acknowledge handshake
// from a slower processor clock domain.
//
//   state  | meaning
//   IDLE   | waiting for a new request toggle
//   CMD    | avm_read/avm_write asserted, waiting for waitrequest low
//   RDWAIT | read accepted, waiting for readdatavalid (USE_RDVALID=1)
//   RESP   | response registered, rsp_toggle flips on leaving
module avmm_master_bridge
  import avmm_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int USE_RDVALID    = 0,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int BE_W          = be_width(DATA_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_toggle,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  input  logic              req_read,
  input  logic              req_write,
  output logic              rsp_toggle,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              busy,
  output logic [ADDR_W-1:0] avm_address,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [BE_W-1:0]   avm_byteenable,
  output logic              avm_read,
  output logic              avm_write,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  avmm_state_t      r_state;
  logic             r_last_seen;
  logic             r_is_read;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_req_sync;
  logic             w_start;
  logic             w_tmo_hit;

  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (req_toggle),
    .o_q     (w_req_sync)
  );

  assign w_start   = w_req_sync ^ r_last_seen;
  // A zero timeout never fires; the counter may wrap harmlessly.
  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_tmo_cnt == TMO_LAST);
  assign busy      = (r_state != ST_IDLE);

  // Transaction sequencer with registered Avalon and response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_last_seen    <= 1'b0;
      r_is_read      <= 1'b0;
      r_tmo_cnt      <= '0;
      avm_address    <= '0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      rsp_toggle     <= 1'b0;
      rsp_rdata      <= '0;
      rsp_error      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_last_seen <= w_req_sync;
            if (req_read ^ req_write) begin
              avm_address    <= req_addr;
              avm_writedata  <= req_wdata;
              avm_byteenable <= req_be;
              avm_read       <= req_read;
              avm_write      <= req_write;
              r_is_read      <= req_read;
              r_tmo_cnt      <= '0;
              r_state        <= ST_CMD;
            end else begin
              // Ambiguous command: answer with an error, no bus cycle.
              rsp_rdata <= '0;
              rsp_error <= 1'b1;
              r_state   <= ST_RESP;
            end
          end
        end
        ST_CMD: begin
          if (!avm_waitrequest) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            if (r_is_read && (USE_RDVALID != 0) && !avm_readdatavalid) begin
              r_state <= ST_RDWAIT;
            end else begin
              rsp_rdata <= r_is_read ? avm_readdata : '0;
              rsp_error <= 1'b0;
              r_state   <= ST_RESP;
            end
          end else if (w_tmo_hit) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b1;
            r_state   <= ST_RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        ST_RDWAIT: begin
          if (avm_readdatavalid) begin
            rsp_rdata <= avm_readdata;
            rsp_error <= 1'b0;
            r_state   <= ST_RESP;
          end else if (w_tmo_hit) begin
            rsp_rdata <= '0;
            rsp_error <= 1'b1;
            r_state   <= ST_RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        ST_RESP: begin
          rsp_toggle <= ~rsp_toggle;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avmm_master_bridge.sv
// Scoreboard bench: two bridge instances (readdata-on-accept and
// readdatavalid completion), both with a 16-cycle bus timeout.
module tb_avmm_master_bridge;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;

  logic        t0 = 1'b0, t1 = 1'b0;
  logic        rsp_toggle0, rsp_error0, busy0, avm_read0, avm_write0;
  logic        rsp_toggle1, rsp_error1, busy1, avm_read1, avm_write1;
  logic [31:0] rsp_rdata0, avm_address0, avm_writedata0;
  logic [31:0] rsp_rdata1, avm_address1, avm_writedata1;
  logic [3:0]  avm_byteenable0, avm_byteenable1;
  logic        wr0 = 1'b0, rdv0 = 1'b0, wr1 = 1'b0, rdv1 = 1'b0;
  logic [31:0] rd0 = '0, rd1 = 32'hBAD0BAD0;

  int          n_checks = 0;
  int          n_fail = 0;
  rsp_t        exp_q0[$];
  rsp_t        exp_q1[$];
  rsp_t        e0, e1;
  logic        prev0 = 1'b0, prev1 = 1'b0;

  int          ws0 = 0, ws_cnt0 = 0, n_rd0 = 0, n_wr0 = 0;
  logic [31:0] exp_addr0 = '0, exp_wdata0 = '0;
  logic [3:0]  exp_be0 = '0;

  always #5 clk = ~clk;

  avmm_master_bridge #(
    .ADDR_W(32), .DATA_W(32), .SYNC_STAGES(2), .USE_RDVALID(0), .TIMEOUT_CYCLES(16)
  ) u_dut0 (
    .clk(clk), .reset_n(reset_n), .req_toggle(t0), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .req_read(req_read), .req_write(req_write),
    .rsp_toggle(rsp_toggle0), .rsp_rdata(rsp_rdata0), .rsp_error(rsp_error0), .busy(busy0),
    .avm_address(avm_address0), .avm_writedata(avm_writedata0),
    .avm_byteenable(avm_byteenable0), .avm_read(avm_read0), .avm_write(avm_write0),
    .avm_waitrequest(wr0), .avm_readdata(rd0), .avm_readdatavalid(rdv0)
  );

  avmm_master_bridge #(
    .ADDR_W(32), .DATA_W(32), .SYNC_STAGES(2), .USE_RDVALID(1), .TIMEOUT_CYCLES(16)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .req_toggle(t1), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .req_read(req_read), .req_write(req_write),
    .rsp_toggle(rsp_toggle1), .rsp_rdata(rsp_rdata1), .rsp_error(rsp_error1), .busy(busy1),
    .avm_address(avm_address1), .avm_writedata(avm_writedata1),
    .avm_byteenable(avm_byteenable1), .avm_read(avm_read1), .avm_write(avm_write1),
    .avm_waitrequest(wr1), .avm_readdata(rd1), .avm_readdatavalid(rdv1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave model for dut0: programmable wait states, checks command stability.
  always @(negedge clk) begin
    if (avm_write0) begin
      n_wr0++;
      chk("wr_addr", avm_address0, exp_addr0);
      chk("wr_data", avm_writedata0, exp_wdata0);
      chk("wr_be", {28'd0, avm_byteenable0}, {28'd0, exp_be0});
    end
    if (avm_read0) begin
      n_rd0++;
      chk("rd_addr", avm_address0, exp_addr0);
    end
    if (avm_read0 || avm_write0) begin
      if (ws_cnt0 < ws0) begin
        wr0 = 1'b1;
        ws_cnt0++;
      end else begin
        wr0 = 1'b0;
      end
    end else begin
      wr0 = 1'b0;
      ws_cnt0 = 0;
    end
  end

  // Response monitor: every rsp_toggle flip pops one expected response.
  always @(negedge clk) begin
    if (reset_n && rsp_toggle0 !== prev0) begin
      if (exp_q0.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rsp0_unexpected: toggle flipped with no pending request");
      end else begin
        e0 = exp_q0.pop_front();
        chk("rsp0_rdata", rsp_rdata0, e0.rdata);
        chk("rsp0_error", {31'd0, rsp_error0}, {31'd0, e0.err});
      end
    end
    prev0 = rsp_toggle0;
    if (reset_n && rsp_toggle1 !== prev1) begin
      if (exp_q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rsp1_unexpected: toggle flipped with no pending request");
      end else begin
        e1 = exp_q1.pop_front();
        chk("rsp1_rdata", rsp_rdata1, e1.rdata);
        chk("rsp1_error", {31'd0, rsp_error1}, {31'd0, e1.err});
      end
    end
    prev1 = rsp_toggle1;
  end

  task automatic wait_rsp(input bit which, input string name);
    logic s;
    int   k;
    s = which ? rsp_toggle1 : rsp_toggle0;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if ((which ? rsp_toggle1 : rsp_toggle0) !== s) break;
    end
    n_checks++;
    if (k == 200) begin
      n_fail++;
      $display("FAIL %s_wait: got no response, required one within 200 cycles", name);
    end
    @(negedge clk);
  endtask

  task automatic issue0(input string name, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int ws, input logic [31:0] bus_rdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_nrd, input int exp_nwr);
    req_read = rd; req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    exp_addr0 = addr; exp_wdata0 = wdata; exp_be0 = be;
    ws0 = ws; rd0 = bus_rdata; n_rd0 = 0; n_wr0 = 0;
    exp_q0.push_back('{exp_rdata, exp_err});
    @(negedge clk);
    t0 = ~t0;
    wait_rsp(1'b0, name);
    chk({name, "_nrd"}, n_rd0, exp_nrd);
    chk({name, "_nwr"}, n_wr0, exp_nwr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_rsp_toggle", {31'd0, rsp_toggle0}, 32'd0);
    chk("reset_busy", {31'd0, busy0}, 32'd0);
    chk("reset_avm_cmd", {30'd0, avm_read0, avm_write0}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata0, 32'd0);
    chk("reset_rsp_error", {31'd0, rsp_error0}, 32'd0);

    issue0("wr_zero_ws", 0, 1, 32'h0000_1000, 32'hDEADBEEF, 4'hF, 0, 32'h0, 32'h0, 0, 0, 1);
    issue0("rd_ws3",     1, 0, 32'h0000_0020, 32'h0, 4'hF, 3, 32'h12345678, 32'h12345678, 0, 4, 0);
    issue0("rd_timeout", 1, 0, 32'h0000_0030, 32'h0, 4'hF, 1000, 32'h55AA55AA, 32'h0, 1, 16, 0);
    repeat (5) @(negedge clk);
    chk("tmo_cmd_dropped", {30'd0, avm_read0, avm_write0}, 32'd0);
    chk("tmo_idle", {31'd0, busy0}, 32'd0);
    chk("tmo_queue_empty", exp_q0.size(), 32'd0);
    issue0("rd_ws0",     1, 0, 32'h0000_0024, 32'h0, 4'hF, 0, 32'hA5A50001, 32'hA5A50001, 0, 1, 0);
    issue0("ill_both",   1, 1, 32'h0000_0028, 32'h0, 4'hF, 0, 32'h0, 32'h0, 1, 0, 0);
    issue0("ill_none",   0, 0, 32'h0000_002C, 32'h0, 4'hF, 0, 32'h0, 32'h0, 1, 0, 0);
    issue0("wr_ws1",     0, 1, 32'h0000_0104, 32'h0000_BEEF, 4'h3, 1, 32'h0, 32'h0, 0, 0, 2);

    // readdatavalid completion five cycles after accept
    req_read = 1'b1; req_write = 1'b0; req_addr = 32'h80;
    exp_q1.push_back('{32'hCAFEF00D, 1'b0});
    @(negedge clk);
    t1 = ~t1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (avm_read1) break;
    end
    chk("rdv_cmd_seen", {31'd0, avm_read1}, 32'd1);
    chk("rdv_addr", avm_address1, 32'h80);
    @(negedge clk);
    chk("rdv_read_dropped", {31'd0, avm_read1}, 32'd0);
    chk("rdv_busy", {31'd0, busy1}, 32'd1);
    repeat (4) @(negedge clk);
    rd1 = 32'hCAFEF00D; rdv1 = 1'b1;
    @(negedge clk);
    rdv1 = 1'b0; rd1 = 32'hBAD0BAD0;
    wait_rsp(1'b1, "rdv_read");

    // stray readdatavalid while idle
    rdv1 = 1'b1; rd1 = 32'h11111111;
    repeat (3) @(negedge clk);
    rdv1 = 1'b0; rd1 = 32'hBAD0BAD0;
    repeat (5) @(negedge clk);
    chk("late_rdv_idle", {31'd0, busy1}, 32'd0);
    chk("late_rdv_toggle", {31'd0, rsp_toggle1}, 32'd1);

    // readdatavalid in the same cycle as the accept
    req_addr = 32'h84;
    exp_q1.push_back('{32'h600DD00D, 1'b0});
    @(negedge clk);
    t1 = ~t1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (avm_read1) break;
    end
    chk("rdv0_cmd_seen", {31'd0, avm_read1}, 32'd1);
    rd1 = 32'h600DD00D; rdv1 = 1'b1;
    @(negedge clk);
    rdv1 = 1'b0; rd1 = 32'hBAD0BAD0;
    wait_rsp(1'b1, "rdv_same_cycle");

    // asynchronous reset in the middle of a stalled read
    req_read = 1'b1; req_write = 1'b0; req_addr = 32'h44;
    exp_addr0 = 32'h44; ws0 = 1000; n_rd0 = 0;
    @(negedge clk);
    t0 = ~t0;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (avm_read0) break;
    end
    chk("rst_cmd_seen", {31'd0, avm_read0}, 32'd1);
    chk("rst_toggle_before", {31'd0, rsp_toggle0}, 32'd1);
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b0; t0 = 1'b0; t1 = 1'b0;
    #1;
    chk("rst_avm_read", {31'd0, avm_read0}, 32'd0);
    chk("rst_avm_write", {31'd0, avm_write0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_rsp_toggle0", {31'd0, rsp_toggle0}, 32'd0);
    chk("rst_rsp_toggle1", {31'd0, rsp_toggle1}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    ws0 = 0;
    @(negedge clk);
    issue0("wr_after_rst", 0, 1, 32'h0000_0050, 32'h0BB0_1234, 4'hF, 0, 32'h0, 32'h0, 0, 0, 1);
    chk("after_rst_toggle", {31'd0, rsp_toggle0}, 32'd1);
    repeat (5) @(negedge clk);
    chk("final_q0_empty", exp_q0.size(), 32'd0);
    chk("final_q1_empty", exp_q1.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
